param_parking_controller: RTL and testbench

//  Parametrised gate controller for one parking-lot entrance: PIN check with configurable

---
 rtl/param_parking_controller.sv | 167 ++++++++++++++++
 tb/tb_param_parking_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_parking_controller.sv
// Gate controller for one parking-lot entrance: PIN check with attempt limit,
// PIN-entry timeout, admin unlock of lockout/alarm, and lot occupancy tracking.
module param_parking_controller #(
    parameter int unsigned          CODE_W       = 16,
    parameter logic [CODE_W-1:0]    CORRECT_CODE = 16'h2468,
    parameter logic [CODE_W-1:0]    ADMIN_CODE   = 16'h1357,
    parameter int unsigned          MAX_ATTEMPTS = 3,
    parameter int unsigned          TIMEOUT_CYC  = 1000,
    parameter int unsigned          CAPACITY     = 8,
    parameter int unsigned          OCC_W        = 4,
    localparam int unsigned         ATT_W        = $clog2(MAX_ATTEMPTS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vehicle_arrival,
    input  logic              vehicle_left,
    input  logic              vehicle_exit,
    input  logic [CODE_W-1:0] code,
    input  logic              code_ack,
    input  logic              gate_ack,
    output logic              open_gate,
    output logic              close_gate,
    output logic              wrong_pin,
    output logic              blocked_gate,
    output logic              lot_full,
    output logic [OCC_W-1:0]  occupancy,
    output logic [ATT_W-1:0]  attempt_cnt
);

    localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWaitPin = 3'd1,
        StWrong   = 3'd2,
        StOpen    = 3'd3,
        StClose   = 3'd4,
        StLockout = 3'd5,
        StAlarm   = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [ATT_W-1:0]   att_q, att_d;
    logic [ATT_W-1:0]   att_inc;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               ack_q;
    logic               entry;
    logic               occ_inc;

    // Only the rising edge of the keypad strobe counts as an entry.
    assign entry    = code_ack & ~ack_q;
    assign att_inc  = att_q + ATT_W'(1);
    assign lot_full = (occ_q == OCC_W'(CAPACITY));

    // Next-state, timer and attempt counter; first matching rule wins.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        att_d   = att_q;
        occ_inc = 1'b0;
        case (state_q)
            StIdle: begin
                if (vehicle_arrival && !lot_full) begin
                    state_d = StWaitPin;
                    timer_d = '0;
                end
            end
            StWaitPin: begin
                if (vehicle_left) begin
                    state_d = StIdle;
                    att_d   = '0;
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    state_d = StIdle;
                    att_d   = '0;
                end else if (entry && (code == CORRECT_CODE)) begin
                    state_d = StOpen;
                    att_d   = '0;
                end else if (entry) begin
                    // Admin code is just another wrong PIN here.
                    att_d   = att_inc;
                    state_d = (att_inc == ATT_W'(MAX_ATTEMPTS)) ? StLockout : StWrong;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            StWrong: begin
                if (!code_ack) begin
                    state_d = StWaitPin;
                    timer_d = '0;
                end
            end
            StOpen: begin
                if (vehicle_left) begin
                    occ_inc = 1'b1;
                    state_d = vehicle_arrival ? StAlarm : StClose;
                end
            end
            StClose: begin
                if (gate_ack) begin
                    state_d = StIdle;
                end
            end
            StLockout, StAlarm: begin
                if (entry && (code == ADMIN_CODE)) begin
                    state_d = StIdle;
                    att_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Occupancy: simultaneous in/out cancels; saturate at both ends.
    always_comb begin
        occ_d = occ_q;
        if (occ_inc && vehicle_exit) begin
            occ_d = occ_q;
        end else if (occ_inc) begin
            if (occ_q != OCC_W'(CAPACITY)) begin
                occ_d = occ_q + OCC_W'(1);
            end
        end else if (vehicle_exit) begin
            if (occ_q != '0) begin
                occ_d = occ_q - OCC_W'(1);
            end
        end
    end

    // Moore output decode from the state register.
    always_comb begin
        open_gate    = 1'b0;
        close_gate   = 1'b0;
        wrong_pin    = 1'b0;
        blocked_gate = 1'b0;
        case (state_q)
            StOpen:             open_gate    = 1'b1;
            StClose:            close_gate   = 1'b1;
            StWrong, StLockout: wrong_pin    = 1'b1;
            StAlarm:            blocked_gate = 1'b1;
            default: ;
        endcase
    end

    assign occupancy   = occ_q;
    assign attempt_cnt = att_q;

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            timer_q <= '0;
            att_q   <= '0;
            occ_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            att_q   <= att_d;
            occ_q   <= occ_d;
            ack_q   <= code_ack;
        end
    end

endmodule

// File: tb/tb_param_parking_controller.sv
// Scoreboard bench: stimulus pushes expected output vectors, a monitor pops and
// compares them on the falling clock edge.
module tb_param_parking_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vehicle_arrival = 1'b0;
    logic        vehicle_left = 1'b0;
    logic        vehicle_exit = 1'b0;
    logic [15:0] code = 16'h0;
    logic        code_ack = 1'b0;
    logic        gate_ack = 1'b0;
    logic        open_gate, close_gate, wrong_pin, blocked_gate, lot_full;
    logic [3:0]  occupancy;
    logic [1:0]  attempt_cnt;

    typedef struct {
        string      name;
        logic [10:0] vec;   // {open, close, wrong, blocked, full, occ[3:0], att[1:0]}
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    param_parking_controller dut (
        .clk             (clk),
        .rst             (rst),
        .vehicle_arrival (vehicle_arrival),
        .vehicle_left    (vehicle_left),
        .vehicle_exit    (vehicle_exit),
        .code            (code),
        .code_ack        (code_ack),
        .gate_ack        (gate_ack),
        .open_gate       (open_gate),
        .close_gate      (close_gate),
        .wrong_pin       (wrong_pin),
        .blocked_gate    (blocked_gate),
        .lot_full        (lot_full),
        .occupancy       (occupancy),
        .attempt_cnt     (attempt_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: one expected vector is compared per falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [10:0] act;
            e   = sb.pop_front();
            act = {open_gate, close_gate, wrong_pin, blocked_gate, lot_full,
                   occupancy, attempt_cnt};
            n_checks++;
            if (act !== e.vec) begin
                n_fail++;
                $display("FAIL %s: got og/cg/wp/bg/full=%b occ=%0d att=%0d, want %b occ=%0d att=%0d",
                         e.name, act[10:6], act[5:2], act[1:0],
                         e.vec[10:6], e.vec[5:2], e.vec[1:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input bit og, input bit cg, input bit wp,
                       input bit bg, input int occ, input int att);
        exp_t e;
        e.name = nm;
        e.vec  = {og, cg, wp, bg, (occ == 8), 4'(occ), 2'(att)};
        sb.push_back(e);
    endtask

    task automatic enter(input logic [15:0] v);
        code     = v;
        code_ack = 1'b1;
        tick();
        code_ack = 1'b0;
    endtask

    task automatic arrive();
        vehicle_arrival = 1'b1;
        tick();
        vehicle_arrival = 1'b0;
    endtask

    // Full admitted pass: arrival, PIN, drive through, gate closes.
    task automatic pass_session();
        arrive();
        enter(16'h2468);
        vehicle_left = 1'b1;
        tick();
        vehicle_left = 1'b0;
        gate_ack = 1'b1;
        tick();
        gate_ack = 1'b0;
    endtask

    initial begin
        tick();
        chk("reset", 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        tick();

        // 1: normal entry
        arrive();
        chk("t1_wait_pin", 0, 0, 0, 0, 0, 0);
        enter(16'h2468);
        chk("t1_open", 1, 0, 0, 0, 0, 0);
        vehicle_left = 1'b1;
        tick();
        vehicle_left = 1'b0;
        chk("t1_close", 0, 1, 0, 0, 1, 0);
        gate_ack = 1'b1;
        tick();
        gate_ack = 1'b0;
        chk("t1_idle", 0, 0, 0, 0, 1, 0);

        // 2: wrong PINs to lockout, admin unlock
        arrive();
        enter(16'h1111);
        chk("t2_wrong1", 0, 0, 1, 0, 1, 1);
        tick();
        chk("t2_retry1", 0, 0, 0, 0, 1, 1);
        enter(16'h1111);
        chk("t2_wrong2", 0, 0, 1, 0, 1, 2);
        tick();
        enter(16'h1111);
        chk("t2_lockout", 0, 0, 1, 0, 1, 3);
        tick();
        enter(16'h2468);
        chk("t2_user_pin_ignored", 0, 0, 1, 0, 1, 3);
        tick();
        enter(16'h1357);
        chk("t2_admin_unlock", 0, 0, 0, 0, 1, 0);

        // 3a: timeout after exactly TIMEOUT_CYC cycles in WAIT_PIN
        arrive();
        enter(16'h1111);
        chk("t3_wrong", 0, 0, 1, 0, 1, 1);
        tick();
        repeat (999) tick();
        chk("t3_before_timeout", 0, 0, 0, 0, 1, 1);
        tick();
        chk("t3_timeout", 0, 0, 0, 0, 1, 0);

        // 3b: held strobe counts once, code change while held ignored
        arrive();
        code     = 16'h1111;
        code_ack = 1'b1;
        tick();
        code = 16'h2468;
        repeat (19) tick();
        chk("t3_held_ack", 0, 0, 1, 0, 1, 1);
        code_ack = 1'b0;
        tick();
        chk("t3_released", 0, 0, 0, 0, 1, 1);
        enter(16'h2468);
        chk("t3_open", 1, 0, 0, 0, 1, 0);
        vehicle_left = 1'b1;
        tick();
        vehicle_left = 1'b0;
        gate_ack = 1'b1;
        tick();
        gate_ack = 1'b0;
        chk("t3_idle", 0, 0, 0, 0, 2, 0);

        // 4: tailgating alarm
        arrive();
        enter(16'h2468);
        vehicle_left    = 1'b1;
        vehicle_arrival = 1'b1;
        tick();
        vehicle_left    = 1'b0;
        vehicle_arrival = 1'b0;
        chk("t4_alarm", 0, 0, 0, 1, 3, 0);
        tick();
        enter(16'h1111);
        chk("t4_wrong_ignored", 0, 0, 0, 1, 3, 0);
        tick();
        enter(16'h1357);
        chk("t4_admin_clear", 0, 0, 0, 0, 3, 0);

        // 5: capacity and saturation
        repeat (5) pass_session();
        chk("t5_full", 0, 0, 0, 0, 8, 0);
        arrive();
        tick();
        enter(16'h2468);
        chk("t5_arrival_ignored", 0, 0, 0, 0, 8, 0);
        vehicle_exit = 1'b1;
        tick();
        vehicle_exit = 1'b0;
        chk("t5_exit", 0, 0, 0, 0, 7, 0);
        arrive();
        enter(16'h2468);
        vehicle_left = 1'b1;
        vehicle_exit = 1'b1;
        tick();
        vehicle_left = 1'b0;
        vehicle_exit = 1'b0;
        chk("t5_inc_dec_cancel", 0, 1, 0, 0, 7, 0);
        gate_ack = 1'b1;
        tick();
        gate_ack = 1'b0;
        vehicle_exit = 1'b1;
        repeat (7) tick();
        vehicle_exit = 1'b0;
        chk("t5_empty", 0, 0, 0, 0, 0, 0);
        vehicle_exit = 1'b1;
        tick();
        vehicle_exit = 1'b0;
        chk("t5_exit_at_zero", 0, 0, 0, 0, 0, 0);

        // 6: asynchronous reset in OPEN with occupancy 5
        repeat (5) pass_session();
        arrive();
        enter(16'h2468);
        chk("t6_open", 1, 0, 0, 0, 5, 0);
        tick();
        #1;
        rst = 1'b0;
        #1;
        chk("t6_async_reset", 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        arrive();
        enter(16'h2468);
        chk("t6_after_reset_open", 1, 0, 0, 0, 0, 0);

        repeat (3) tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
